// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one SD sector-read engine between the 140K (0) and 840K (1) FDD track loaders.
// Drives the engine's read/readok handshake, guards each wait with a watchdog, and steers RAM writes to the grantee.
module sd_read_arbiter #(
  parameter int SECW  = 32,
  parameter int TMO_W = 24
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            cardinit,
  input  logic [1:0]      req,
  input  logic [SECW-1:0] sec0,
  input  logic [SECW-1:0] sec1,
  output logic [1:0]      grant,
  output logic [1:0]      done,
  output logic [1:0]      err,
  output logic            sd_read,
  output logic [SECW-1:0] sd_sec,
  input  logic            sd_readok,
  input  logic            sd_wren,
  output logic [1:0]      wren
);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;

  // The watchdog holds the number of cycles already spent in the current wait state,
  // so the (2^TMO_W-1)th cycle is the one that sees 2^TMO_W-2 and times out.
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [2:0]       state;
  logic [TMO_W-1:0] wdog;
  logic             last;
  logic             pick;
  logic             wdog_expired;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pick = last;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = last;
    endcase
  end

  assign wdog_expired = (wdog == WDOG_LAST);
  assign wren         = {2{sd_wren}} & grant;

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously on nreset low.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= S_INIT;
      grant   <= 2'b00;
      done    <= 2'b00;
      err     <= 2'b00;
      sd_read <= 1'b0;
      sd_sec  <= '1;
      wdog    <= '0;
      last    <= 1'b1;
    end else begin
      done <= 2'b00;
      err  <= 2'b00;
      if (state != S_INIT && !cardinit) begin
        // Card lost: abort whatever is in flight; err is silent when nobody holds the grant.
        err     <= grant;
        grant   <= 2'b00;
        sd_read <= 1'b0;
        state   <= S_INIT;
      end else begin
        case (state)
          S_INIT: begin
            if (cardinit) state <= S_IDLE;
          end
          S_IDLE: begin
            if (req != 2'b00) begin
              grant  <= pick ? 2'b10 : 2'b01;
              sd_sec <= pick ? sec1 : sec0;
              last   <= pick;
              state  <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            sd_read <= 1'b1;
            wdog    <= '0;
            state   <= S_WAIT_LO;
          end
          S_WAIT_LO: begin
            if (!sd_readok) begin
              sd_read <= 1'b0;
              wdog    <= '0;
              state   <= S_WAIT_HI;
            end else if (wdog_expired) begin
              sd_read <= 1'b0;
              err     <= grant;
              grant   <= 2'b00;
              state   <= S_IDLE;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          S_WAIT_HI: begin
            if (sd_readok) begin
              done  <= grant;
              grant <= 2'b00;
              state <= S_IDLE;
            end else if (wdog_expired) begin
              err   <= grant;
              grant <= 2'b00;
              state <= S_IDLE;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          default: begin
            grant   <= 2'b00;
            sd_read <= 1'b0;
            state   <= S_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares one SD-card sector-read engine between two disk-image track loaders: requester 0 is the 140K FDD path, requester 1 is the 840K FDD path.
- Accepts sector-read requests from both sides and grants them round-robin.
- Drives the engine's read/readok handshake and steers the engine's RAM write strobe to the granted requester only.
- Sits between the FDD controllers and the single SD engine instance.

Parameters:
- SECW, 32, width of SD sector (LBA) number.
- TMO_W, 24, width of handshake watchdog counter; timeout after 2^TMO_W-1 cycles in one wait state.

Ports:
- clk  in  1  system clock.
- nreset  in  1  reset, asynchronous, active-low.
- cardinit  in  1  SD engine initialised; level.
- req  in  2  per-requester read request; level, held until matching done/err.
- sec0  in  SECW  sector requested by requester 0; must be stable while req[0]=1.
- sec1  in  SECW  sector requested by requester 1; must be stable while req[1]=1.
- grant  out  2  one-hot registered grant; 00 when idle.
- done  out  2  one-cycle pulse: the granted read completed.
- err  out  2  one-cycle pulse: the granted read timed out or was aborted.
- sd_read  out  1  read strobe to SD engine.
- sd_sec  out  SECW  sector to SD engine; latched at grant.
- sd_readok  in  1  engine ready/complete flag.
- sd_wren  in  1  engine RAM write enable.
- wren  out  2  wren[i] = sd_wren & grant[i]; combinational.

Behaviour:
- Reset values: grant=00, done=00, err=00, sd_read=0, sd_sec=all ones, watchdog=0, last-served pointer=1, state=INIT.
- INIT: wait for cardinit=1, then go to IDLE.
- IDLE:
  - If req=00, stay.
  - If exactly one request bit is set, grant it.
  - If req=11, grant the requester other than last-served.
  - On grant, same cycle: grant<=onehot, sd_sec<=selected sec, last<=index; go to ISSUE.
- ISSUE: sd_read<=1, watchdog cleared; go to WAIT_LO.
- WAIT_LO: wait for sd_readok=0, then sd_read<=0 and go to WAIT_HI.
- WAIT_HI: wait for sd_readok=1; then done[g] pulses for 1 cycle, grant<=00, go to IDLE.
- Latency:
  - Minimum grant-to-done is 4 cycles (ISSUE, WAIT_LO, WAIT_HI, done) when readok toggles immediately.
  - A new grant may start the cycle after done (IDLE arbitration takes 1 cycle).
- Watchdog:
  - Counts every cycle in WAIT_LO/WAIT_HI.
  - At terminal count: sd_read<=0, err[g] pulses, grant<=00, go to IDLE.
  - The timed-out requester counts as served.
- cardinit falling in any non-INIT state: abort immediately; sd_read<=0, grant<=00, err pulses for the current grantee (if any), go to INIT.
- Request withdrawn (req[g] drops) during a transfer: the transfer runs to completion; done is still pulsed; the requester ignores it.
- Requester re-asserting in the cycle after its own done is allowed. If the other side is pending, the other side wins.
- sd_sec changes only at grant; sec0/sec1 changes during a transfer are ignored.
- wren is only ever nonzero for the granted side; while grant=00, wren=00 regardless of sd_wren.
- done and err are mutually exclusive and never both asserted in the same cycle.

Test Plan:
1. Reset, cardinit=1, req=01, sec0=0x1C7, readok held 1 then low 2 cycles then high -> grant=01, sd_sec=0x1C7, sd_read high until readok low, done=01 pulse exactly once, grant=00.
2. req=11 held, engine model completes each read in 10 cycles -> grants alternate 01,10,01,10 (requester 0 first after reset); no gap >1 idle cycle between transfers.
3. During requester-1 transfer, sd_wren toggles 512 times -> wren[1] mirrors sd_wren 512 times, wren[0]=0 throughout; after done, sd_wren=1 gives wren=00.
4. TMO_W=4, engine never drops readok -> err[g] pulses at cycle 15 in WAIT_LO, sd_read=0, next pending request granted.
5. Drop cardinit mid-WAIT_HI -> err pulse, grant=00, sd_read=0, no grant issued until cardinit=1 again; then the pending request is served normally.
6. Async nreset asserted mid-transfer -> all outputs at reset values immediately without a clock edge; after release, the first grant goes to requester 0 when req=11.
